mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store initiator for the MIPS datapath. It sits between the MEM stage and the byte-addressed, big-endian data memory. It accepts one load or store request at a time from the pipeline and issues word-wide read and write transactions to memory. Sub-word stores use read-modify-write, and loads are extracted and sign- or zero-extended. Misaligned accesses are flagged without touching memory.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width (fixed 32; other values unsupported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  unit can accept a request
req_op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
req_addr  in  ADDR_W  byte address, from ALU result
req_wdata  in  32  store data, from rd2; low bits used for SB/SH
resp_valid  out  1  response valid
resp_ready  in  1  pipeline accepts response
resp_data  out  32  load result, extended; 0 for stores
resp_err  out  1  misaligned access
mem_addr  out  ADDR_W  word-aligned byte address, low 2 bits always 0
mem_re  out  1  read request
mem_we  out  1  write request
mem_wdata  out  32  write word, big-endian
mem_ready  in  1  memory accepts the current mem_re/mem_we this cycle
mem_rvalid  in  1  mem_rdata valid, at least 1 cycle after the accepted read
mem_rdata  in  32  read word, big-endian

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. req_ready=1 is the only asserted output. resp_valid, resp_err, mem_re, mem_we=0. resp_data, mem_addr, mem_wdata=0. Reset mid-transaction abandons it: no response, and any pending mem_rvalid is ignored.
- Handshake: a transfer occurs when valid&&ready at a posedge. req_ready=1 only in IDLE. The request is captured into internal regs (op, addr, wdata).
- Big-endian lane mapping: offset 0 → bits[31:24], offset 3 → bits[7:0]. Halfword at offset 0 → [31:16]; offset 2 → [15:0].
- Alignment: LH/LHU/SH require addr[0]=0. LW/SW require addr[1:0]=0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
  - IDLE, on accept:
    - misaligned → RESP with err=1
    - SW → WR_REQ
    - any load, SB or SH → RD_REQ
  - RD_REQ: mem_re=1, mem_addr={addr[31:2],2'b00}. Advance to RD_WAIT on mem_ready; hold otherwise.
  - RD_WAIT: wait for mem_rvalid.
    - Load: latch the extracted, extended value into resp_data, then go to RESP.
    - SB/SH: latch the merged word into mem_wdata (only the target lane replaced by req_wdata[7:0] or [15:0]), then go to WR_REQ.
  - WR_REQ: mem_we=1, same mem_addr. For SW, mem_wdata=req_wdata. Advance to RESP on mem_ready.
  - RESP: resp_valid=1. Return to IDLE when resp_ready=1.
- resp_data and resp_err are stable while resp_valid=1. mem_addr, mem_re, mem_we and mem_wdata are stable while the request is waiting for mem_ready.
- Extension: LB/LH sign-extend from the selected lane MSB. LBU/LHU zero-extend.
- Error response: resp_data=0 and resp_err=1. No mem_re or mem_we is ever asserted for a misaligned request.
- mem_re and mem_we are never high together. At most one transaction is outstanding.
- Minimum latency, accept to resp_valid, with mem_ready=1 and rvalid one cycle later:
  - SW: 2 cycles
  - loads: 3 cycles
  - SB/SH: 4 cycles
  - misaligned: 1 cycle
- A new req_valid is ignored, and not dropped, while busy because req_ready=0. Back-to-back operation: response accepted in cycle N, next request accepted in cycle N+1.

Decomposition:
- Package mips_mem_pkg holds:
  - the op enum (LB..SW) and FSM state enum
  - constants OP_IS_STORE and OP_SIZE decode helpers
  - lane-offset constants
- One combinational sub-module, mem_lane_align:
  - inputs: op, addr[1:0], old word, store data, read word
  - outputs: merged store word, extended load value, misaligned flag
- The FSM, capture registers and handshake logic stay in the top level.

Test Plan:
- Memory word 0x10 = 0x8091A2B3. LB @0x11 → resp_data=0xFFFFFF91. LBU @0x11 → 0x00000091. LH @0x12 → 0xFFFFA2B3. LHU @0x10 → 0x00008091.
- SW @0x20 with 0xDEADBEEF, mem_ready=1 → single mem_we with mem_wdata=0xDEADBEEF, no mem_re, resp_valid 2 cycles after accept.
- Memory 0x20 = 0xDEADBEEF. SB @0x22 with wdata 0x12345677 → write word 0xDEAD77EF. Then SH @0x20 with 0xAAAA5555 → write word 0x555577EF.
- LW @0x06 and SH @0x13 → resp_err=1, resp_data=0, zero mem_re/mem_we pulses, resp_valid 1 cycle after accept.
- Backpressure: mem_ready low 3 cycles during RD_REQ, mem_rvalid delayed 2 cycles, resp_ready low 2 cycles → outputs held stable, LW @0x10 still returns 0x8091A2B3, req_ready stays 0 throughout.
- rst_n=0 while in RD_WAIT of a SB → next cycle IDLE with req_ready=1, no mem_we ever issued, a late mem_rvalid ignored, no resp_valid.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared definitions for the MIPS load/store unit: the memory
//               op encoding, FSM state codes, op decode tables and the
//               big-endian lane offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    // FSM state codes
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    // Access size codes
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Decode tables indexed by op code (bit n / field n belongs to op n)
    localparam logic [7:0]  OP_IS_STORE = 8'b1110_0000;
    localparam logic [15:0] OP_SIZE     = {SIZE_WORD, SIZE_HALF, SIZE_BYTE,
                                           SIZE_WORD, SIZE_HALF, SIZE_HALF,
                                           SIZE_BYTE, SIZE_BYTE};
    localparam logic [7:0]  OP_IS_SIGNED = 8'b0000_0101;

    // Big-endian lane offsets: byte offset 0 is the most significant lane
    localparam logic [1:0] BYTE_OFF_0  = 2'd0;   // bits [31:24]
    localparam logic [1:0] BYTE_OFF_1  = 2'd1;   // bits [23:16]
    localparam logic [1:0] BYTE_OFF_2  = 2'd2;   // bits [15:8]
    localparam logic [1:0] BYTE_OFF_3  = 2'd3;   // bits [7:0]
    localparam logic [1:0] HALF_OFF_LO = 2'd2;   // bits [15:0]

    function automatic logic op_is_store(input logic [2:0] op);
        return OP_IS_STORE[op];
    endfunction

    function automatic logic [1:0] op_size(input logic [2:0] op);
        return OP_SIZE[{op, 1'b0} +: 2];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return OP_IS_SIGNED[op];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational big-endian lane logic. Extracts and extends
//               load data, merges sub-word store data into an old word and
//               flags misaligned accesses.
// Ports       : i_op          - memory op code
//               i_addr_lo     - byte offset within the word
//               i_old_word    - word being modified by a sub-word store
//               i_store_data  - store data (low bits used for SB/SH)
//               i_rd_word     - word returned by memory for a load
//               o_merged_word - word to write back
//               o_load_val    - extracted, extended load value
//               o_misaligned  - access violates its natural alignment
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rd_word,
    output logic [31:0] o_merged_word,
    output logic [31:0] o_load_val,
    output logic        o_misaligned
);

    logic [1:0]  w_size;
    logic        w_sext;
    logic        w_half_lo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_size    = op_size(i_op);
        w_sext    = op_is_signed(i_op);
        w_half_lo = ({i_addr_lo[1], 1'b0} == HALF_OFF_LO);

        o_misaligned = ((w_size == SIZE_HALF) && i_addr_lo[0]) ||
                       ((w_size == SIZE_WORD) && (i_addr_lo != 2'b00));

        case (i_addr_lo)
            BYTE_OFF_0: w_byte = i_rd_word[31:24];
            BYTE_OFF_1: w_byte = i_rd_word[23:16];
            BYTE_OFF_2: w_byte = i_rd_word[15:8];
            default:    w_byte = i_rd_word[7:0];
        endcase
        w_half = w_half_lo ? i_rd_word[15:0] : i_rd_word[31:16];

        case (w_size)
            SIZE_BYTE: o_load_val = {{24{w_sext & w_byte[7]}}, w_byte};
            SIZE_HALF: o_load_val = {{16{w_sext & w_half[15]}}, w_half};
            default:   o_load_val = i_rd_word;
        endcase

        // Only the addressed lane is replaced; all other lanes keep old data
        o_merged_word = i_old_word;
        case (w_size)
            SIZE_BYTE: begin
                case (i_addr_lo)
                    BYTE_OFF_0: o_merged_word[31:24] = i_store_data[7:0];
                    BYTE_OFF_1: o_merged_word[23:16] = i_store_data[7:0];
                    BYTE_OFF_2: o_merged_word[15:8]  = i_store_data[7:0];
                    default:    o_merged_word[7:0]   = i_store_data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (w_half_lo) o_merged_word[15:0]  = i_store_data[15:0];
                else           o_merged_word[31:16] = i_store_data[15:0];
            end
            default: o_merged_word = i_store_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator between the MIPS MEM stage and a
//               big-endian, byte-addressed data memory. One request at a
//               time; sub-word stores are read-modify-write; misaligned
//               requests are answered with an error and never reach memory.
// Ports       : clk, rst_n                  - clock, sync active-low reset
//               req_valid/ready/op/addr/wdata - pipeline request
//               resp_valid/ready/data/err    - pipeline response
//               mem_addr/re/we/wdata/ready   - memory request channel
//               mem_rvalid/rdata             - memory read return
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [2:0]        r_state;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_idle;
    logic [2:0]        w_op;
    logic [1:0]        w_addr_lo;
    logic [31:0]       w_merged;
    logic [31:0]       w_load_val;
    logic              w_misaligned;

    // In IDLE the alignment check must look at the incoming request; in
    // every other state the lane logic works on the captured request.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_op      = w_idle ? req_op       : r_op;
    assign w_addr_lo = w_idle ? req_addr[1:0] : r_addr[1:0];

    mem_lane_align u_lane_align (
        .i_op          (w_op),
        .i_addr_lo     (w_addr_lo),
        .i_old_word    (mem_rdata),
        .i_store_data  (r_wdata),
        .i_rd_word     (mem_rdata),
        .o_merged_word (w_merged),
        .o_load_val    (w_load_val),
        .o_misaligned  (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b0;
                        if (w_misaligned) begin
                            r_resp_err <= 1'b1;
                            r_state    <= ST_RESP;
                        end else if (req_op == OP_SW) begin
                            r_mem_wdata <= req_wdata;
                            r_state     <= ST_WR_REQ;
                        end else begin
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_ready) r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        if (op_is_store(r_op)) begin
                            r_mem_wdata <= w_merged;
                            r_state     <= ST_WR_REQ;
                        end else begin
                            r_resp_data <= w_load_val;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (mem_ready) r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = w_idle;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign mem_re     = (r_state == ST_RD_REQ);
    assign mem_we     = (r_state == ST_WR_REQ);
    assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. A byte-array
//               reference memory predicts load results, error flags, memory
//               traffic and final memory contents; a word-array memory
//               device with adjustable stalls services the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB  = 3'd5, SH = 3'd6, SW  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference memory (bytes, big-endian) and memory device (words)
    logic [7:0]  ref_mem [0:255];
    logic [31:0] mem_words [0:63];

    // Memory device controls
    bit          rand_mode   = 0;
    int          rv_delay    = 0;
    int          stall_target = 0;
    int          stall_epoch  = 0;
    int          seen_epoch   = 0;
    int          stall_left   = 0;

    // Memory device state (posedge side)
    bit          rd_pend = 0;
    int          rd_cnt  = 0;
    logic [31:0] rd_word = '0;
    int          re_cnt  = 0;
    int          we_cnt  = 0;
    logic [31:0] last_wdata = '0;
    int          proto_err = 0;
    bit          hold_v = 0;
    logic        h_re, h_we;
    logic [31:0] h_addr, h_wdata;

    always @(posedge clk) begin
        if (rst_n && mem_re && mem_ready) begin
            rd_pend <= 1'b1;
            rd_cnt  <= rv_delay;
            rd_word <= mem_words[mem_addr[7:2]];
            re_cnt  <= re_cnt + 1;
        end else if (rd_pend) begin
            if (rd_cnt == 0) rd_pend <= 1'b0;
            else             rd_cnt  <= rd_cnt - 1;
        end
        if (rst_n && mem_we && mem_ready) begin
            mem_words[mem_addr[7:2]] <= mem_wdata;
            we_cnt     <= we_cnt + 1;
            last_wdata <= mem_wdata;
        end
        // Protocol monitor: exclusivity, alignment, stability under stall
        if (rst_n) begin
            if ((mem_re && mem_we) || (mem_addr[1:0] != 2'b00) ||
                (hold_v && (mem_re !== h_re || mem_we !== h_we ||
                            mem_addr !== h_addr || (mem_we && mem_wdata !== h_wdata))))
                proto_err <= proto_err + 1;
            hold_v <= (mem_re || mem_we) && !mem_ready;
        end else begin
            hold_v <= 1'b0;
        end
        h_re    <= mem_re;
        h_we    <= mem_we;
        h_addr  <= mem_addr;
        h_wdata <= mem_wdata;
    end

    // Memory device drive (negedge side)
    always @(negedge clk) begin
        if (stall_epoch != seen_epoch) begin
            seen_epoch = stall_epoch;
            stall_left = stall_target;
        end
        if (mem_re && stall_left > 0) begin
            mem_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            mem_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        mem_rvalid = rd_pend && (rd_cnt == 0);
        mem_rdata  = mem_rvalid ? rd_word : $urandom;
    end

    // Reference model: predicts response, memory traffic and the written word
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] d, output logic err,
                         output int n_re, output int n_we, output logic [31:0] word);
        int sz, ai, wa;
        logic [31:0] v;
        sz   = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
        ai   = int'(a[7:0]);
        err  = (ai % sz) != 0;
        d = '0; n_re = 0; n_we = 0; word = '0;
        if (err) return;
        if (op <= LW) begin
            n_re = 1;
            v = '0;
            for (int i = 0; i < sz; i++) v = (v << 8) | 32'(ref_mem[ai + i]);
            if ((op == LB || op == LH) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            d = v;
        end else begin
            n_we = 1;
            n_re = (sz < 4) ? 1 : 0;
            for (int i = 0; i < sz; i++) ref_mem[ai + i] = 8'(wd >> (8*(sz-1-i)));
            wa = ai & ~3;
            word = {ref_mem[wa], ref_mem[wa+1], ref_mem[wa+2], ref_mem[wa+3]};
        end
    endtask

    // One complete request/response transaction with checks
    task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input int rr_delay, input bit chk_lat, output logic [31:0] got);
        logic [31:0] exp_d, exp_word, d0;
        logic        exp_err, e0;
        int          exp_re, exp_we, re0, we0, lat, busy, unstable, waits, exp_lat;
        model(op, a, wd, exp_d, exp_err, exp_re, exp_we, exp_word);
        re0 = re_cnt; we0 = we_cnt;
        busy = 0; unstable = 0; lat = 0; waits = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        while (!req_ready && waits < 100) begin @(negedge clk); waits++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready) busy++;
        end while (!resp_valid && lat < 200);
        if (!resp_valid) check("resp_timeout", 32'd1, 32'd0);
        d0 = resp_data; e0 = resp_err; got = resp_data;
        repeat (rr_delay) begin
            @(negedge clk);
            if (resp_data !== d0 || resp_err !== e0 || !resp_valid) unstable++;
            if (req_ready) busy++;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check($sformatf("data op%0d @%02h", op, a[7:0]), resp_data, exp_d);
        check($sformatf("err op%0d @%02h", op, a[7:0]), 32'(e0), 32'(exp_err));
        check("re_count", re_cnt - re0, exp_re);
        check("we_count", we_cnt - we0, exp_we);
        check("busy_ready", busy, 0);
        check("resp_stable", unstable, 0);
        if (exp_we != 0) check("write_word", last_wdata, exp_word);
        if (chk_lat) begin
            exp_lat = exp_err ? 1 : (op == SW) ? 2 : (op <= LW) ? 3 : 4;
            check("latency", lat, exp_lat);
        end
    endtask

    initial begin
        logic [31:0] got, a;
        logic [2:0]  op;
        int          re0, we0, activity;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'h80; ref_mem[8'h11] = 8'h91;
        ref_mem[8'h12] = 8'hA2; ref_mem[8'h13] = 8'hB3;
        for (int w = 0; w < 64; w++)
            mem_words[w] = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        check("rst_mem_re",     32'(mem_re),     32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_resp_data",  resp_data,       32'd0);
        check("rst_mem_addr",   mem_addr,        32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        rst_n = 1'b1;

        // Directed loads, zero-wait memory
        run_req(LB,  32'h11, 32'h0, 0, 1, got); check("tp_lb",  got, 32'hFFFF_FF91);
        run_req(LBU, 32'h11, 32'h0, 0, 1, got); check("tp_lbu", got, 32'h0000_0091);
        run_req(LH,  32'h12, 32'h0, 0, 1, got); check("tp_lh",  got, 32'hFFFF_A2B3);
        run_req(LHU, 32'h10, 32'h0, 0, 1, got); check("tp_lhu", got, 32'h0000_8091);

        // Stores and read-modify-write
        run_req(SW, 32'h20, 32'hDEAD_BEEF, 0, 1, got);
        check("tp_sw_word", last_wdata, 32'hDEAD_BEEF);
        run_req(SB, 32'h22, 32'h1234_5677, 0, 1, got);
        check("tp_sb_word", last_wdata, 32'hDEAD_77EF);
        run_req(SH, 32'h20, 32'hAAAA_5555, 0, 1, got);
        check("tp_sh_word", last_wdata, 32'h5555_77EF);

        // Misaligned
        run_req(LW, 32'h06, 32'h0, 0, 1, got);
        run_req(SH, 32'h13, 32'hFFFF_FFFF, 0, 1, got);

        // Backpressure: 3 stall cycles on the read, late rvalid, slow consumer
        stall_target = 3; stall_epoch++; rv_delay = 2;
        run_req(LW, 32'h10, 32'h0, 2, 0, got);
        check("tp_bp_lw", got, 32'h8091_A2B3);
        rv_delay = 0;

        // Reset while a SB waits for read data
        re0 = re_cnt; we0 = we_cnt; rv_delay = 3;
        @(negedge clk);
        req_valid = 1'b1; req_op = SB; req_addr = 32'h31; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("rst_mid_re", re_cnt - re0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready),  32'd1);
        check("rst_mid_valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        activity = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid || mem_re || mem_we) activity++;
        end
        check("rst_mid_quiet", activity, 0);
        check("rst_mid_no_we", we_cnt - we0, 0);
        rv_delay = 0;

        // Randomized traffic with random stalls
        rand_mode = 1;
        for (int n = 0; n < 200; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
                if (op == LW || op == SW) a[1:0] = 2'b00;
            end
            rv_delay = $urandom_range(0, 2);
            run_req(op, a, $urandom, $urandom_range(0, 2), 0, got);
        end
        rand_mode = 0;
        repeat (4) @(negedge clk);

        for (int w = 0; w < 64; w++)
            check($sformatf("mem_word %02h", 4*w), mem_words[w],
                  {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]});
        check("protocol", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
